aes_key_stream: RTL and testbench
=================================

# aes_key_stream

Byte-serial AES-128 key expansion and round-key streamer. It sits directly upstream of the byte-serial `decrypt` datapath and drives that block's 8-bit `key` input. It accepts a 16-byte cipher key and expands it into 11 round keys held in a 176-byte store. It then streams one 16-byte round key per request in decryption order (round 10 down to round 0), one byte per cycle.

## Interface
- NR, 10, number of AES rounds; the store holds (NR+1)*16 bytes
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous, active-low reset
- key_in  in  8  cipher-key byte; byte 0 is the MSB of word w0
- key_in_valid  in  1  qualifies key_in
- key_req  in  1  single-cycle pulse requesting the next round key
- key_out  out  8  round-key byte (registered)
- key_valid  out  1  high for the 16 cycles a round key is on key_out
- round_out  out  4  index of the round key currently streaming
- key_last  out  1  high with byte 15 of round 0
- ready  out  1  expansion complete; key_req will be accepted
- busy  out  1  high in LOAD and EXPAND

## Operation
- States: IDLE, LOAD, EXPAND, READY, STREAM.
- IDLE → LOAD on the first key_in_valid; that byte is written to address 0.
- LOAD: bytes are written to addresses 0..15 on every key_in_valid. Gaps are allowed. After address 15 is written → EXPAND.
- EXPAND: one byte per cycle, k = 16..175. Let i = k/4 and b = k%4.
  - If i%4 != 0: mem[k] = mem[k-16] ^ mem[k-4].
  - If i%4 == 0: mem[k] = mem[k-16] ^ SBOX(mem[k-4-b+((b+1)%4)]) ^ (b==0 ? RCON[i/4] : 0).
  - RCON = 01,02,04,08,10,20,40,80,1B,36.
  - Write of k=175 → READY.
- READY: key_req → STREAM. Bytes are issued from round pointer r, in order 0..15.
- STREAM: 16 cycles, then back to READY. r then decrements. After round 0, r wraps to 10, so the next block reuses the same schedule.
- key_req in any state other than READY is ignored; requests are not queued.
- key_in_valid in READY restarts LOAD at address 0 (re-key). key_in_valid in EXPAND or STREAM is ignored.
- ready is low from the re-key onward until the new expansion completes.

## Timing
- Reset state: all outputs 0; state IDLE; r = 10; byte counter 0. The 176-byte store is not reset.
- Reset mid-operation: returns to IDLE immediately. The partial schedule is discarded and ready stays 0 until a full reload.
- EXPAND lasts exactly 160 cycles. ready rises the cycle after k=175 is written.
- key_req sampled high in cycle t → key_valid high t+1..t+16, with bytes 0..15 on key_out and round_out = r.
- ready is low during STREAM and high again at t+17.
- key_req at t+17 gives back-to-back rounds with no gap.

## Configuration
- `AES_KEY_STREAM_FWD_ORDER_EN`:
  - Defined: rounds stream 0..10 and r wraps 10→0. key_last marks byte 15 of round 10. This serves the encrypt path.
  - Undefined: decryption order 10..0, as described above.

## Structure
- Shared package `aes_pkg`:
  - RCON table
  - NR and NB_BYTES=16 constants
  - key-stream state enum
  - store address width (8 bits)
- One combinational sub-module, `aes_sbox` (forward S-box, 8→8), instantiated once in the EXPAND path.
- The store is a flop array with two combinational read ports and one write port.

## Test plan
- Reset released; load key 2b7e151628aed2a6abf7158809cf4f3c → busy for 16+160 cycles. ready rises exactly 1 cycle after the last expansion write.
- key_req after expansion → key_out d0,14,f9,a8,c9,ee,25,89,e1,3f,0c,c8,b6,63,0c,a6 with round_out=10.
- Ten further requests → round 1 bytes a0fafe1788542cb123a339392a6c7605. Round 0 equals the cipher key, with key_last on its final byte.
- Twelfth request → wraps to round 10 (d014f9a8...). key_req pulsed during STREAM and during EXPAND produces no extra output.
- key_in_valid bursts with random gaps during LOAD → identical round-10 key. reset_n asserted at EXPAND cycle 80 → all outputs 0 and state IDLE. A subsequent reload expands correctly.
- Build with `AES_KEY_STREAM_FWD_ORDER_EN` → first request yields round 0 = 2b7e1516... and the second yields a0fafe17...

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, round-constant table and key-stream state encoding.
package aes_pkg;

    localparam int NR       = 10;
    localparam int NB_BYTES = 16;
    localparam int AW       = 8;

    typedef logic [AW-1:0] addr_t;

    typedef enum logic [2:0] {IDLE, LOAD, EXPAND, READY, STREAM} ks_state_t;

    // Indexed by i/4 (1..10); unused slots keep the lookup total over a 4-bit index.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box, purely combinational 8->8 lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so address the table from the other end.
    assign y = SBOX[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_stream.sv
// aes_key_stream: byte-serial AES-128 key expansion and round-key streamer for the decrypt datapath.
// Define AES_KEY_STREAM_FWD_ORDER_EN to stream rounds 0..NR (encrypt order) instead of NR..0.
module aes_key_stream
    import aes_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] key_in,
    input  logic       key_in_valid,
    input  logic       key_req,
    output logic [7:0] key_out,
    output logic       key_valid,
    output logic [3:0] round_out,
    output logic       key_last,
    output logic       ready,
    output logic       busy
);

    logic [7:0] mem [(NR+1)*NB_BYTES];
    ks_state_t  state;
    addr_t      k, ra, rb, wa;
    logic [3:0] r, r_next, cnt;
    logic [7:0] sb, xb, wd;
    logic       rot, start, we;

`ifdef AES_KEY_STREAM_FWD_ORDER_EN
    localparam logic [3:0] R_FIRST = 4'd0;
    localparam logic [3:0] R_LAST  = 4'(NR);
    assign r_next = r == R_LAST ? R_FIRST : r + 4'd1;
`else
    localparam logic [3:0] R_FIRST = 4'(NR);
    localparam logic [3:0] R_LAST  = 4'd0;
    assign r_next = r == R_LAST ? R_FIRST : r - 4'd1;
`endif

    // Port B reads w[i-1]; on the first word of each group it is byte-rotated for RotWord.
    always_comb begin
        rot   = k[3:2] == 2'd0;
        ra    = state == EXPAND ? k - 8'd16 : {r, cnt};
        rb    = {k[7:2] - 6'd1, rot ? k[1:0] + 2'd1 : k[1:0]};
        xb    = mem[ra] ^ (rot ? sb ^ (k[1:0] == 2'd0 ? RCON[k[7:4]] : 8'h00) : mem[rb]);
        start = key_in_valid && (state == IDLE || state == READY);
        we    = start || (state == LOAD && key_in_valid) || state == EXPAND;
        wa    = start ? '0 : k;
        wd    = state == EXPAND ? xb : key_in;
    end

    aes_sbox u_sbox (
        .a (mem[rb]),
        .y (sb)
    );

    always_ff @(posedge clock) begin
        if (we) mem[wa] <= wd;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            k         <= '0;
            r         <= R_FIRST;
            cnt       <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            round_out <= '0;
            key_last  <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (key_in_valid) begin
                        state <= LOAD;
                        k     <= 8'd1;
                        r     <= R_FIRST;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end else if (state == READY && key_req) begin
                        state     <= STREAM;
                        key_out   <= mem[ra];
                        key_valid <= 1'b1;
                        round_out <= r;
                        cnt       <= 4'd1;
                        ready     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (key_in_valid) begin
                        k <= k + 8'd1;
                        if (k == 8'd15) state <= EXPAND;
                    end
                end
                EXPAND: begin
                    k <= k + 8'd1;
                    if (k == 8'd175) begin
                        state <= READY;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                STREAM: begin
                    // cnt wraps to 0 once byte 15 has been issued.
                    if (cnt == 4'd0) begin
                        state     <= READY;
                        key_valid <= 1'b0;
                        key_last  <= 1'b0;
                        ready     <= 1'b1;
                        r         <= r_next;
                    end else begin
                        key_out  <= mem[ra];
                        cnt      <= cnt + 4'd1;
                        key_last <= cnt == 4'd15 && r == R_LAST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_stream.sv
// tb_aes_key_stream: directed table-driven bench for aes_key_stream using the FIPS-197 key schedule.
module tb_aes_key_stream;

    logic       clock = 1'b0, reset_n = 1'b0, key_in_valid = 1'b0, key_req = 1'b0;
    logic [7:0] key_in = 8'h00, key_out;
    logic       key_valid, key_last, ready, busy;
    logic [3:0] round_out;
    int         passed = 0, total = 0;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        logic         last;
    } vec_t;

    vec_t         tbl [12];
    logic [127:0] rk [11];
    logic [127:0] ck;

`ifdef AES_KEY_STREAM_FWD_ORDER_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [3:0] R_LAST = FWD ? 4'd10 : 4'd0;

    always #5 clock = ~clock;

    aes_key_stream dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .key_in       (key_in),
        .key_in_valid (key_in_valid),
        .key_req      (key_req),
        .key_out      (key_out),
        .key_valid    (key_valid),
        .round_out    (round_out),
        .key_last     (key_last),
        .ready        (ready),
        .busy         (busy)
    );

    function automatic logic [3:0] ord(input int n);
        return FWD ? 4'(n % 11) : 4'(10 - n % 11);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic load_key(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clock);
            key_in       = ck[127 - 8*i -: 8];
            key_in_valid = 1'b1;
            @(negedge clock);
            key_in_valid = 1'b0;
        end
    endtask

    // Called at the negedge right after the last key byte was taken.
    task automatic wait_ready();
        int   n    = 0;
        logic seen = 1'b0;
        chk("busy_in_expand", busy, 1);
        chk("ready_low_in_expand", ready, 0);
        while (!ready && n < 400) begin
            key_req = (n == 40);
            @(negedge clock);
            n++;
            seen |= key_valid;
        end
        key_req = 1'b0;
        chk("expand_cycles", n, 160);
        chk("req_in_expand_ignored", seen, 0);
        chk("busy_after_expand", busy, 0);
    endtask

    // Called at a negedge while ready is high; exp_round < 0 accepts any reported round.
    task automatic do_req(input int exp_round, input logic [127:0] exp_key, input logic exp_last, input bit poke);
        logic [127:0] kb;
        logic [15:0]  vm, lm;
        logic [3:0]   rnd;
        logic         seen = 1'b0;
        key_req = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            key_req = poke && j == 5;
            if (j == 0) rnd = round_out;
            kb[127 - 8*j -: 8] = key_out;
            vm[15 - j] = key_valid;
            lm[15 - j] = key_last;
        end
        if (exp_round >= 0) begin
            chk("round_out", rnd, exp_round);
            chk("round_key", kb, exp_key);
            chk("key_last", lm, {15'd0, exp_last});
        end else begin
            chk("round_in_range", rnd <= 4'd10, 1);
            chk("round_key", kb, rk[rnd % 11]);
            chk("key_last", lm, {15'd0, rnd == R_LAST});
        end
        chk("valid_span", vm, 16'hffff);
        @(negedge clock);
        chk("ready_after_stream", {key_valid, ready}, 2'b01);
        if (poke) begin
            repeat (3) begin
                @(negedge clock);
                seen |= key_valid;
            end
            chk("req_in_stream_ignored", seen, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        ck     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[0]  = ck;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int n = 0; n < 12; n++) begin
            tbl[n].round = ord(n);
            tbl[n].key   = rk[ord(n)];
            tbl[n].last  = ord(n) == R_LAST;
        end

        repeat (2) @(negedge clock);
        chk("reset_outputs", {key_out, key_valid, round_out, key_last, ready, busy}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        load_key(1'b0);
        wait_ready();
        for (int n = 0; n < 12; n++) do_req(int'(tbl[n].round), tbl[n].key, tbl[n].last, 1'b0);
        do_req(int'(ord(12)), rk[ord(12)], ord(12) == R_LAST, 1'b1);
        do_req(int'(ord(13)), rk[ord(13)], ord(13) == R_LAST, 1'b0);

        reset_n = 1'b0;
        #1;
        chk("reset_after_stream", {key_out, key_valid, round_out, key_last, ready, busy}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        load_key(1'b1);
        wait_ready();
        do_req(int'(ord(0)), rk[ord(0)], ord(0) == R_LAST, 1'b0);

        load_key(1'b0);
        repeat (80) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("reset_mid_expand", {key_out, key_valid, round_out, key_last, ready, busy}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        key_req = 1'b1;
        begin
            logic seen = 1'b0;
            repeat (5) begin
                @(negedge clock);
                key_req = 1'b0;
                seen |= key_valid | ready | busy;
            end
            chk("idle_after_reset", seen, 0);
        end
        load_key(1'b0);
        wait_ready();
        do_req(int'(ord(0)), rk[ord(0)], ord(0) == R_LAST, 1'b0);
        do_req(int'(ord(1)), rk[ord(1)], ord(1) == R_LAST, 1'b0);

        load_key(1'b1);
        wait_ready();
        do_req(-1, '0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
